// File: rtl/ext_reg_req_ctrl.sv
// Request sequencer between a CPU access port and one external register.
// Optional hung-target timeout: define EXT_REQ_TIMEOUT_EN.
module ext_reg_req_ctrl #(
  parameter int WIDTH    = 32,
  parameter int SUBWORDS = 1,
  parameter int SEL_W    = (SUBWORDS > 1) ? $clog2(SUBWORDS) : 1,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid_i,
  output logic                cpu_req_ready_o,
  input  logic                cpu_req_is_wr_i,
  input  logic [SEL_W-1:0]    cpu_sel_i,
  input  logic [WIDTH-1:0]    cpu_wr_data_i,
  input  logic [WIDTH-1:0]    cpu_wr_biten_i,
  output logic                cpu_rsp_valid_o,
  output logic [WIDTH-1:0]    cpu_rsp_rd_data_o,
  output logic                cpu_rsp_err_o,
  output logic [SUBWORDS-1:0] ext_req_o,
  output logic                ext_req_is_wr_o,
  output logic [WIDTH-1:0]    ext_wr_data_o,
  output logic [WIDTH-1:0]    ext_wr_biten_o,
  input  logic                ext_rd_ack_i,
  input  logic [WIDTH-1:0]    ext_rd_data_i,
  input  logic                ext_wr_ack_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [SEL_W:0] SEL_LIM = (SEL_W+1)'(SUBWORDS);

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_rd_data_q, rsp_rd_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [SUBWORDS-1:0] ext_req_q, ext_req_d;
  logic                is_wr_q, is_wr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [WIDTH-1:0]    wr_biten_q, wr_biten_d;
  logic                sel_oob, ack_match, timeout;

  assign sel_oob   = {1'b0, cpu_sel_i} >= SEL_LIM;
  assign ack_match = is_wr_q ? ext_wr_ack_i : ext_rd_ack_i;

`ifdef EXT_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter reads k on the k-th WAIT cycle, so expiry lands where an ack
  // TIMEOUT cycles after ext_req would.
  assign timeout = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == REQ)
      cnt_d = CNT_W'(1);
    else if (state_q == WAIT && cnt_q != CNT_W'(TIMEOUT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_rd_data_d = '0;
    rsp_err_d     = 1'b0;
    ext_req_d     = '0;
    is_wr_d       = is_wr_q;
    wr_data_d     = wr_data_q;
    wr_biten_d    = wr_biten_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid_i && ready_q) begin
          if (sel_oob) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = REQ;
            ext_req_d  = SUBWORDS'(1) << cpu_sel_i;
            is_wr_d    = cpu_req_is_wr_i;
            wr_data_d  = cpu_wr_data_i;
            wr_biten_d = cpu_wr_biten_i;
          end
        end
      end
      REQ, WAIT: begin
        if (ack_match) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_rd_data_d = is_wr_q ? '0 : ext_rd_data_i;
        end else if (timeout) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d    = IDLE;
        is_wr_d    = 1'b0;
        wr_data_d  = '0;
        wr_biten_d = '0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_err_q     <= 1'b0;
      ext_req_q     <= '0;
      is_wr_q       <= 1'b0;
      wr_data_q     <= '0;
      wr_biten_q    <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_err_q     <= rsp_err_d;
      ext_req_q     <= ext_req_d;
      is_wr_q       <= is_wr_d;
      wr_data_q     <= wr_data_d;
      wr_biten_q    <= wr_biten_d;
    end
  end

  assign cpu_req_ready_o   = ready_q;
  assign cpu_rsp_valid_o   = rsp_valid_q;
  assign cpu_rsp_rd_data_o = rsp_rd_data_q;
  assign cpu_rsp_err_o     = rsp_err_q;
  assign ext_req_o         = ext_req_q;
  assign ext_req_is_wr_o   = is_wr_q;
  assign ext_wr_data_o     = wr_data_q;
  assign ext_wr_biten_o    = wr_biten_q;

endmodule

// File: tb/tb_ext_reg_req_ctrl.sv
// Directed bench for ext_reg_req_ctrl (SUBWORDS=5 so sel 5..7 are out of range).
module tb_ext_reg_req_ctrl;
  localparam int WIDTH = 32;
  localparam int SUBWORDS = 5;
  localparam int SEL_W = 3;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_req_valid = 1'b0, cpu_req_is_wr = 1'b0;
  logic [SEL_W-1:0] cpu_sel = '0;
  logic [WIDTH-1:0] cpu_wr_data = '0, cpu_wr_biten = '0;
  logic ext_rd_ack = 1'b0, ext_wr_ack = 1'b0;
  logic [WIDTH-1:0] ext_rd_data = 32'hBAD0BAD0;
  logic cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, ext_req_is_wr;
  logic [WIDTH-1:0] cpu_rsp_rd_data, ext_wr_data, ext_wr_biten;
  logic [SUBWORDS-1:0] ext_req;

  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ext_reg_req_ctrl #(.WIDTH(WIDTH), .SUBWORDS(SUBWORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid_i(cpu_req_valid), .cpu_req_ready_o(cpu_req_ready),
    .cpu_req_is_wr_i(cpu_req_is_wr), .cpu_sel_i(cpu_sel),
    .cpu_wr_data_i(cpu_wr_data), .cpu_wr_biten_i(cpu_wr_biten),
    .cpu_rsp_valid_o(cpu_rsp_valid), .cpu_rsp_rd_data_o(cpu_rsp_rd_data),
    .cpu_rsp_err_o(cpu_rsp_err), .ext_req_o(ext_req),
    .ext_req_is_wr_o(ext_req_is_wr), .ext_wr_data_o(ext_wr_data),
    .ext_wr_biten_o(ext_wr_biten), .ext_rd_ack_i(ext_rd_ack),
    .ext_rd_data_i(ext_rd_data), .ext_wr_ack_i(ext_wr_ack)
  );

  typedef struct {
    logic             is_wr;
    logic [SEL_W-1:0] sel;
    logic [31:0]      data;
    logic [31:0]      biten;
    int               delay;   // ack cycle relative to ext_req, -1 = never
    logic [31:0]      tgt;
    logic             stray;   // wrong-type ack the cycle before the real one
    logic             exp_err;
    logic [31:0]      exp_rd;
    int               lat;     // accept cycle -> cpu_rsp_valid cycle
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(logic w, logic [SEL_W-1:0] s, logic [31:0] d, logic [31:0] b,
                              int dl, logic [31:0] t, logic st, logic e, logic [31:0] r, int l);
    vec_t v;
    v.is_wr = w; v.sel = s; v.data = d; v.biten = b; v.delay = dl; v.tgt = t;
    v.stray = st; v.exp_err = e; v.exp_rd = r; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(cpu_req_ready), 0);
    chk({tag, "_rspv"}, 64'(cpu_rsp_valid), 0);
    chk({tag, "_rsprd"}, 64'(cpu_rsp_rd_data), 0);
    chk({tag, "_rsperr"}, 64'(cpu_rsp_err), 0);
    chk({tag, "_extreq"}, 64'(ext_req), 0);
    chk({tag, "_iswr"}, 64'(ext_req_is_wr), 0);
    chk({tag, "_wdata"}, 64'(ext_wr_data), 0);
    chk({tag, "_biten"}, 64'(ext_wr_biten), 0);
  endtask

  // All driving and sampling happens at negedge; cycle k = k-th negedge after accept.
  task automatic run_txn(input vec_t v, input string tag, output int acc);
    logic [SUBWORDS-1:0] one;
    bit got = 0;
    int k;
    for (int w = 0; w < 20 && !cpu_req_ready; w++) @(negedge clk);
    chk({tag, "_ready_wait"}, 64'(cpu_req_ready), 1);
    acc = cyc;
    one = SUBWORDS'(1) << v.sel;
    cpu_req_valid = 1'b1; cpu_req_is_wr = v.is_wr; cpu_sel = v.sel;
    cpu_wr_data = v.data; cpu_wr_biten = v.biten;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (k = 1; k <= 60 && !got; k++) begin
      chk($sformatf("%s_extreq_c%0d", tag, k), 64'(ext_req), (!v.exp_err && k == 1) ? 64'(one) : 0);
      chk($sformatf("%s_busy_c%0d", tag, k), 64'(cpu_req_ready), 0);
      if (k == 1 && !v.exp_err) begin
        chk({tag, "_iswr"}, 64'(ext_req_is_wr), 64'(v.is_wr));
        if (v.is_wr) begin
          chk({tag, "_wdata"}, 64'(ext_wr_data), 64'(v.data));
          chk({tag, "_biten"}, 64'(ext_wr_biten), 64'(v.biten));
        end
      end
      if (cpu_rsp_valid) begin
        got = 1;
        chk({tag, "_lat"}, 64'(k), 64'(v.lat));
        chk({tag, "_rd"}, 64'(cpu_rsp_rd_data), 64'(v.exp_rd));
        chk({tag, "_err"}, 64'(cpu_rsp_err), 64'(v.exp_err));
      end
      ext_rd_ack = 1'b0; ext_wr_ack = 1'b0; ext_rd_data = 32'hBAD0BAD0;
      if (!got && v.delay >= 0 && k == 1 + v.delay) begin
        if (v.is_wr) ext_wr_ack = 1'b1;
        else begin ext_rd_ack = 1'b1; ext_rd_data = v.tgt; end
      end else if (!got && v.stray && v.delay >= 1 && k == v.delay) begin
        if (v.is_wr) ext_rd_ack = 1'b1;
        else ext_wr_ack = 1'b1;
      end
      @(negedge clk);
    end
    ext_rd_ack = 1'b0; ext_wr_ack = 1'b0; ext_rd_data = 32'hBAD0BAD0;
    if (!got) chk({tag, "_rsp_timeout"}, 0, 1);
    chk({tag, "_rsp_1cyc"}, 64'(cpu_rsp_valid), 0);
    chk({tag, "_ready_back"}, 64'(cpu_req_ready), 1);
  endtask

  task automatic expect_no_rsp(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_norsp%0d", tag, i), 64'(cpu_rsp_valid), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc, prev;
    vec_t v;
    tbl[0] = mk(0, 3'd2, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 5);
    tbl[1] = mk(1, 3'd1, 32'hA5A5A5A5, 32'h0000FFFF, 1, 32'h12345678, 1, 0, 32'h0, 3);
    tbl[2] = mk(0, 3'd5, 32'h0, 32'h0, -1, 32'h0, 0, 1, 32'h0, 1);
    tbl[3] = mk(1, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h0, 0, 1, 32'h0, 1);
    tbl[4] = mk(0, 3'd0, 32'h0, 32'h0, 0, 32'h00000001, 0, 0, 32'h00000001, 2);
    tbl[5] = mk(0, 3'd4, 32'h0, 32'h0, 2, 32'h80000000, 1, 0, 32'h80000000, 4);
    tbl[6] = mk(1, 3'd3, 32'h13579BDF, 32'hF0F0F0F0, 0, 32'hCAFEF00D, 0, 0, 32'h0, 2);
    tbl[7] = mk(0, 3'd1, 32'h0, 32'h0, 5, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 7);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cpu_req_ready), 1);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i), acc);

    // Reset one cycle after ext_req: transaction dropped, late ack ignored.
    cpu_req_valid = 1'b1; cpu_req_is_wr = 1'b0; cpu_sel = 3'd2;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    chk("mrst_extreq", 64'(ext_req), 64'h4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mrst_a");
    @(negedge clk);
    chk_all_zero("mrst_b");
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ready", 64'(cpu_req_ready), 1);
    ext_rd_ack = 1'b1; ext_rd_data = 32'h55555555;
    @(negedge clk);
    ext_rd_ack = 1'b0; ext_rd_data = 32'hBAD0BAD0;
    expect_no_rsp("mrst", 3);
    run_txn(mk(0, 3'd3, 0, 0, 1, 32'h600DF00D, 0, 0, 32'h600DF00D, 3), "mrst_next", acc);

`ifdef EXT_REQ_TIMEOUT_EN
    // Hung target: error response 17 cycles after ext_req, then a late ack.
    run_txn(mk(0, 3'd3, 0, 0, -1, 0, 0, 1, 32'h0, TIMEOUT + 2), "tmo", acc);
    ext_rd_ack = 1'b1; ext_rd_data = 32'h77777777;
    @(negedge clk);
    ext_rd_ack = 1'b0; ext_rd_data = 32'hBAD0BAD0;
    expect_no_rsp("tmo_late", 3);
`else
    // No timeout: WAIT holds well past TIMEOUT until the ack comes.
    run_txn(mk(0, 3'd3, 0, 0, 25, 32'h0BADCAFE, 0, 0, 32'h0BADCAFE, 27), "hold", acc);
`endif
    run_txn(mk(1, 3'd4, 32'h01020304, 32'hFF00FF00, 2, 0, 0, 0, 32'h0, 4), "after", acc);

    // Back-to-back zero-delay reads: one accept every 3 cycles.
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      v = mk(0, 3'(i % SUBWORDS), 0, 0, 0, 32'h10000000 + i, 0, 0, 32'h10000000 + i, 2);
      run_txn(v, $sformatf("b2b%0d", i), acc);
      if (prev >= 0) chk($sformatf("b2b%0d_gap", i), 64'(acc - prev), 3);
      prev = acc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
